// File: rtl/wb_sched_pkg.sv
// Shared constants, FSM state encoding and slot-entry layout for the writeback commit scheduler.
package wb_sched_pkg;

  localparam int unsigned N_SLOT = 16;
  localparam int unsigned IDX_W  = $clog2(N_SLOT);
  localparam int unsigned NSRC   = 6;
  localparam int unsigned AREG_W = 5;
  localparam int unsigned XLEN   = 32;

  typedef enum logic [1:0] {IDLE, RUN, END} sched_state_e;

  typedef struct packed {
    logic              done;
    logic              store;
    logic [AREG_W-1:0] areg;
    logic [XLEN-1:0]   result;
  } slot_t;

  // Slot index carried by completion source s in the flattened index bus.
  function automatic logic [IDX_W-1:0] src_idx(input logic [NSRC*IDX_W-1:0] v,
                                               input int unsigned s);
    return v[s*IDX_W +: IDX_W];
  endfunction

endpackage

// File: rtl/wb_commit_sched_if.sv
// Retire-side handshakes: GRF write port and dcache store-release port.
interface wb_commit_sched_if;
  import wb_sched_pkg::*;

  logic              o_grfValid;
  logic              i_grfReady;
  logic [AREG_W-1:0] o_grfAreg_5;
  logic [XLEN-1:0]   o_grfData_32;
  logic              o_stValid;
  logic              i_stReady;
  logic [IDX_W-1:0]  o_stIdx_4;

  modport master (output o_grfValid, o_grfAreg_5, o_grfData_32, o_stValid, o_stIdx_4,
                  input  i_grfReady, i_stReady);
  modport slave  (input  o_grfValid, o_grfAreg_5, o_grfData_32, o_stValid, o_stIdx_4,
                  output i_grfReady, i_stReady);

endinterface

// File: rtl/wb_slot_table.sv
// Window slot table: priority multi-source completion write, clear on window start, read at ptr.
module wb_slot_table
  import wb_sched_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr_i,
  input  logic [NSRC-1:0]          cmp_valid_i,
  input  logic [NSRC*IDX_W-1:0]    cmp_idx_i,
  input  logic [NSRC*AREG_W-1:0]   cmp_areg_i,
  input  logic [NSRC*XLEN-1:0]     cmp_result_i,
  input  logic [NSRC-1:0]          cmp_store_i,
  input  logic [IDX_W-1:0]         rd_idx_i,
  output slot_t                    rd_entry_c_o,
  output logic                     cmp_err_c_o
);

  slot_t tbl_q [N_SLOT];
  slot_t tbl_d [N_SLOT];

  // Highest source written first so the lowest-numbered source lands last and wins.
  always_comb begin
    tbl_d       = tbl_q;
    cmp_err_c_o = 1'b0;
    if (clr_i) begin
      for (int k = 0; k < int'(N_SLOT); k++) tbl_d[k] = '0;
    end
    for (int s = int'(NSRC) - 1; s >= 0; s--) begin
      if (cmp_valid_i[s]) begin
        tbl_d[src_idx(cmp_idx_i, s)] = '{done:   1'b1,
                                         store:  cmp_store_i[s],
                                         areg:   cmp_areg_i[s*AREG_W +: AREG_W],
                                         result: cmp_result_i[s*XLEN +: XLEN]};
        if (tbl_q[src_idx(cmp_idx_i, s)].done && !clr_i) cmp_err_c_o = 1'b1;
        for (int j = 0; j < s; j++) begin
          if (cmp_valid_i[j] && (src_idx(cmp_idx_i, j) == src_idx(cmp_idx_i, s)))
            cmp_err_c_o = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < int'(N_SLOT); k++) tbl_q[k] <= '0;
    end else begin
      tbl_q <= tbl_d;
    end
  end

  assign rd_entry_c_o = tbl_q[rd_idx_i];

endmodule

// File: rtl/wb_commit_sched.sv
// In-order commit scheduler: retires done window slots into GRF writes or store releases.
module wb_commit_sched
  import wb_sched_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_start,
  input  logic [IDX_W-1:0]         i_lastIdx_4,
  input  logic [NSRC-1:0]          i_cmpValid,
  input  logic [NSRC*IDX_W-1:0]    i_cmpIdx,
  input  logic [NSRC*AREG_W-1:0]   i_cmpAreg,
  input  logic [NSRC*XLEN-1:0]     i_cmpResult,
  input  logic [NSRC-1:0]          i_cmpStore,
  input  logic                     i_truncValid,
  input  logic [IDX_W-1:0]         i_truncIdx_4,
  wb_commit_sched_if.master        wb_if,
  output logic [IDX_W-1:0]         o_commitPtr_4,
  output logic                     o_cycleEnd,
  output logic                     o_err
);

  sched_state_e      state_q, state_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [IDX_W-1:0]  limit_q, limit_d;
  logic              grf_valid_q, grf_valid_d;
  logic [AREG_W-1:0] grf_areg_q, grf_areg_d;
  logic [XLEN-1:0]   grf_data_q, grf_data_d;
  logic              st_valid_q, st_valid_d;
  logic [IDX_W-1:0]  st_idx_q, st_idx_d;
  logic              cycle_end_q, cycle_end_d;
  logic              err_q, err_d;

  logic              clr_c;
  logic              tbl_err_c;
  slot_t             rd_c;
  logic [IDX_W-1:0]  lim_eff_c;
  logic              grf_free_c, st_free_c, drained_c;

  wb_slot_table u_table (
    .clk          (clk),
    .rst          (rst),
    .clr_i        (clr_c),
    .cmp_valid_i  (i_cmpValid),
    .cmp_idx_i    (i_cmpIdx),
    .cmp_areg_i   (i_cmpAreg),
    .cmp_result_i (i_cmpResult),
    .cmp_store_i  (i_cmpStore),
    .rd_idx_i     (ptr_q),
    .rd_entry_c_o (rd_c),
    .cmp_err_c_o  (tbl_err_c)
  );

  // An output register can take a new slot if empty or draining this cycle.
  assign grf_free_c = !grf_valid_q || wb_if.i_grfReady;
  assign st_free_c  = !st_valid_q  || wb_if.i_stReady;
  assign drained_c  = grf_free_c && st_free_c;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    limit_d     = limit_q;
    grf_valid_d = grf_valid_q && !wb_if.i_grfReady;
    grf_areg_d  = grf_areg_q;
    grf_data_d  = grf_data_q;
    st_valid_d  = st_valid_q && !wb_if.i_stReady;
    st_idx_d    = st_idx_q;
    cycle_end_d = 1'b0;
    err_d       = err_q || tbl_err_c;
    clr_c       = 1'b0;
    lim_eff_c   = limit_q;

    unique case (state_q)
      IDLE: begin
        if (i_start) begin
          state_d = RUN;
          ptr_d   = '0;
          limit_d = i_lastIdx_4;
          clr_c   = 1'b1;
        end
      end
      RUN: begin
        if (i_start) err_d = 1'b1;
        // Truncation lowers the limit already for this cycle's end-of-window test.
        if (i_truncValid) begin
          if (i_truncIdx_4 < ptr_q)        err_d     = 1'b1;
          else if (i_truncIdx_4 < limit_q) lim_eff_c = i_truncIdx_4;
        end
        limit_d = lim_eff_c;
        if (rd_c.done && (rd_c.store ? st_free_c : ((rd_c.areg != '0) ? grf_free_c : 1'b1))) begin
          if (rd_c.store) begin
            st_valid_d = 1'b1;
            st_idx_d   = ptr_q;
          end else if (rd_c.areg != '0) begin
            grf_valid_d = 1'b1;
            grf_areg_d  = rd_c.areg;
            grf_data_d  = rd_c.result;
          end
          if (ptr_q == lim_eff_c) state_d = END;
          else                    ptr_d   = ptr_q + IDX_W'(1);
        end
      end
      END: begin
        if (i_start) err_d = 1'b1;
        if (drained_c) begin
          cycle_end_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      limit_q     <= IDX_W'(N_SLOT - 1);
      grf_valid_q <= 1'b0;
      grf_areg_q  <= '0;
      grf_data_q  <= '0;
      st_valid_q  <= 1'b0;
      st_idx_q    <= '0;
      cycle_end_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      limit_q     <= limit_d;
      grf_valid_q <= grf_valid_d;
      grf_areg_q  <= grf_areg_d;
      grf_data_q  <= grf_data_d;
      st_valid_q  <= st_valid_d;
      st_idx_q    <= st_idx_d;
      cycle_end_q <= cycle_end_d;
      err_q       <= err_d;
    end
  end

  assign wb_if.o_grfValid   = grf_valid_q;
  assign wb_if.o_grfAreg_5  = grf_areg_q;
  assign wb_if.o_grfData_32 = grf_data_q;
  assign wb_if.o_stValid    = st_valid_q;
  assign wb_if.o_stIdx_4    = st_idx_q;
  assign o_commitPtr_4      = ptr_q;
  assign o_cycleEnd         = cycle_end_q;
  assign o_err              = err_q;

endmodule

// File: tb/tb_wb_commit_sched.sv
// Directed bench for wb_commit_sched with a queue scoreboard and a negedge output monitor.
module tb_wb_commit_sched;
  import wb_sched_pkg::*;

  typedef struct packed {
    logic [AREG_W-1:0] areg;
    logic [XLEN-1:0]   data;
  } grf_exp_t;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   i_start;
  logic [IDX_W-1:0]       i_lastIdx_4;
  logic [NSRC-1:0]        cmp_valid;
  logic [NSRC*IDX_W-1:0]  cmp_idx;
  logic [NSRC*AREG_W-1:0] cmp_areg;
  logic [NSRC*XLEN-1:0]   cmp_result;
  logic [NSRC-1:0]        cmp_store;
  logic                   trunc_valid;
  logic [IDX_W-1:0]       trunc_idx;
  logic [IDX_W-1:0]       commit_ptr;
  logic                   cycle_end;
  logic                   err;

  wb_commit_sched_if wbif();

  wb_commit_sched dut (
    .clk          (clk),
    .rst          (rst),
    .i_start      (i_start),
    .i_lastIdx_4  (i_lastIdx_4),
    .i_cmpValid   (cmp_valid),
    .i_cmpIdx     (cmp_idx),
    .i_cmpAreg    (cmp_areg),
    .i_cmpResult  (cmp_result),
    .i_cmpStore   (cmp_store),
    .i_truncValid (trunc_valid),
    .i_truncIdx_4 (trunc_idx),
    .wb_if        (wbif),
    .o_commitPtr_4(commit_ptr),
    .o_cycleEnd   (cycle_end),
    .o_err        (err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int cend_seen    = 0;
  int cend_pending = 0;
  grf_exp_t         grf_q[$];
  logic [IDX_W-1:0] st_q[$];
  int               grf_stamp[$];
  int               cend_stamp[$];
  grf_exp_t         mon_g;
  logic [IDX_W-1:0] mon_s;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endfunction

  function automatic void exp_grf(input int areg, input int data);
    grf_q.push_back('{areg: AREG_W'(areg), data: XLEN'(data)});
  endfunction

  // Monitor: compare every accepted transfer and every cycle-end pulse against the queues.
  always @(negedge clk) begin
    if (!rst) begin
      if (wbif.o_grfValid && wbif.i_grfReady) begin
        grf_stamp.push_back(cyc);
        if (grf_q.size() == 0) begin
          n_checks++;
          $display("FAIL grf_unexpected: got areg %0d data 0x%0h, expected no write",
                   wbif.o_grfAreg_5, wbif.o_grfData_32);
        end else begin
          mon_g = grf_q.pop_front();
          chk("grf_areg", 64'(wbif.o_grfAreg_5), 64'(mon_g.areg));
          chk("grf_data", 64'(wbif.o_grfData_32), 64'(mon_g.data));
        end
      end
      if (wbif.o_stValid && wbif.i_stReady) begin
        if (st_q.size() == 0) begin
          n_checks++;
          $display("FAIL st_unexpected: got idx %0d, expected no release", wbif.o_stIdx_4);
        end else begin
          mon_s = st_q.pop_front();
          chk("st_idx", 64'(wbif.o_stIdx_4), 64'(mon_s));
        end
      end
      if (cycle_end) begin
        cend_stamp.push_back(cyc);
        cend_seen++;
        if (cend_pending == 0) begin
          n_checks++;
          $display("FAIL cycle_end_unexpected: got pulse at cycle %0d, expected none", cyc);
        end else begin
          cend_pending--;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input int last);
    i_start     = 1'b1;
    i_lastIdx_4 = IDX_W'(last);
    tick();
    i_start     = 1'b0;
  endtask

  task automatic set_cmp(input int s, input int idx, input int areg, input int res, input logic st);
    cmp_valid[s]                  = 1'b1;
    cmp_idx[s*IDX_W +: IDX_W]     = IDX_W'(idx);
    cmp_areg[s*AREG_W +: AREG_W]  = AREG_W'(areg);
    cmp_result[s*XLEN +: XLEN]    = XLEN'(res);
    cmp_store[s]                  = st;
  endtask

  task automatic cmp_tick();
    tick();
    cmp_valid = '0;
    cmp_store = '0;
  endtask

  task automatic wait_cend(input int budget);
    int  base = cend_seen;
    bit  seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (cend_seen > base) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    if (!seen) begin
      n_checks++;
      $display("FAIL cycle_end_timeout: got no pulse in %0d cycles, expected one", budget);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1);
  end

  initial begin
    int c0;
    int base;
    rst = 1'b1; i_start = 1'b0; i_lastIdx_4 = '0;
    cmp_valid = '0; cmp_idx = '0; cmp_areg = '0; cmp_result = '0; cmp_store = '0;
    trunc_valid = 1'b0; trunc_idx = '0;
    wbif.i_grfReady = 1'b1; wbif.i_stReady = 1'b1;
    repeat (3) tick();
    chk("rst_grf_valid", 64'(wbif.o_grfValid), 64'(0));
    chk("rst_st_valid",  64'(wbif.o_stValid),  64'(0));
    chk("rst_ptr",       64'(commit_ptr),      64'(0));
    chk("rst_cycle_end", 64'(cycle_end),       64'(0));
    chk("rst_err",       64'(err),             64'(0));
    rst = 1'b0;
    tick();

    // Reverse-order completions retire in slot order, back to back.
    exp_grf(1, 'h10); exp_grf(2, 'h20); exp_grf(3, 'h30); exp_grf(4, 'h40);
    cend_pending++;
    start(3);
    set_cmp(2, 3, 4, 'h40, 1'b0); cmp_tick();
    set_cmp(5, 2, 3, 'h30, 1'b0); cmp_tick();
    set_cmp(1, 1, 2, 'h20, 1'b0); cmp_tick();
    set_cmp(0, 0, 1, 'h10, 1'b0); cmp_tick();
    c0 = cyc;
    wait_cend(20);
    chk("t1_grf_count", 64'(grf_stamp.size()), 64'(4));
    if (grf_stamp.size() >= 4 && cend_stamp.size() >= 1) begin
      chk("t1_first_latency", 64'(grf_stamp[0]), 64'(c0 + 1));
      for (int i = 1; i < 4; i++) chk("t1_back_to_back", 64'(grf_stamp[i]), 64'(grf_stamp[0] + i));
      chk("t1_cend_latency", 64'(cend_stamp[0]), 64'(grf_stamp[3] + 1));
    end

    // GRF write, store release, then an areg=0 slot that is skipped.
    exp_grf(7, 'hAA);
    st_q.push_back(IDX_W'(1));
    cend_pending++;
    start(2);
    set_cmp(0, 0, 7, 'hAA, 1'b0);
    set_cmp(1, 1, 9, 'h55, 1'b1);
    set_cmp(2, 2, 0, 'h77, 1'b0);
    cmp_tick();
    wait_cend(20);
    chk("t2_err", 64'(err), 64'(0));

    // Backpressure: data held stable, ptr stalls, then drain at one per cycle.
    base = grf_stamp.size();
    wbif.i_grfReady = 1'b0;
    exp_grf(1, 'h101); exp_grf(2, 'h202); exp_grf(3, 'h303); exp_grf(4, 'h404);
    cend_pending++;
    start(3);
    for (int k = 0; k < 4; k++) set_cmp(k, k, k + 1, (k + 1) * 'h101, 1'b0);
    cmp_tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", 64'(wbif.o_grfValid),   64'(1));
      chk("stall_areg",  64'(wbif.o_grfAreg_5),  64'(1));
      chk("stall_data",  64'(wbif.o_grfData_32), 64'('h101));
      chk("stall_ptr",   64'(commit_ptr),        64'(1));
      tick();
    end
    wbif.i_grfReady = 1'b1;
    wait_cend(20);
    if (grf_stamp.size() >= base + 4) begin
      for (int i = 1; i < 4; i++) chk("t3_drain_rate", 64'(grf_stamp[base + i]), 64'(grf_stamp[base] + i));
    end else begin
      chk("t3_grf_count", 64'(grf_stamp.size()), 64'(base + 4));
    end
    chk("t3_err", 64'(err), 64'(0));

    // Truncation to slot 5 at ptr=2; a later truncation below ptr is flagged.
    for (int k = 0; k < 6; k++) exp_grf(10 + k, 'h1000 + k);
    cend_pending++;
    start(15);
    set_cmp(0, 0, 10, 'h1000, 1'b0);
    set_cmp(1, 1, 11, 'h1001, 1'b0);
    cmp_tick();
    tick();
    tick();
    chk("t4_ptr_at_trunc", 64'(commit_ptr), 64'(2));
    trunc_valid = 1'b1; trunc_idx = IDX_W'(5);
    tick();
    trunc_idx = IDX_W'(1);
    tick();
    trunc_valid = 1'b0;
    chk("t4_err_low_trunc", 64'(err), 64'(1));
    for (int k = 0; k < 6; k++) set_cmp(k, k + 2, 12 + k, 'h1002 + k, 1'b0);
    cmp_tick();
    wait_cend(20);
    repeat (5) tick();
    chk("t4_ptr_end", 64'(commit_ptr), 64'(5));

    // Two sources on one slot: source 0 wins and the error flag sets.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_err_cleared", 64'(err), 64'(0));
    for (int k = 0; k < 4; k++) exp_grf(20 + k, 'h2000 + k);
    exp_grf(5, 'hAAAA);
    cend_pending++;
    start(4);
    set_cmp(0, 4, 5, 'hAAAA, 1'b0);
    set_cmp(3, 4, 6, 'hBBBB, 1'b0);
    set_cmp(1, 0, 20, 'h2000, 1'b0);
    set_cmp(2, 1, 21, 'h2001, 1'b0);
    set_cmp(4, 2, 22, 'h2002, 1'b0);
    set_cmp(5, 3, 23, 'h2003, 1'b0);
    cmp_tick();
    chk("t5_err_collision", 64'(err), 64'(1));
    wait_cend(20);

    // Reset mid-window drops the pending write; a fresh window then runs cleanly.
    wbif.i_grfReady = 1'b0;
    start(3);
    set_cmp(0, 0, 9, 'h9, 1'b0);
    cmp_tick();
    tick();
    chk("t6_pending_valid", 64'(wbif.o_grfValid), 64'(1));
    rst = 1'b1;
    tick();
    chk("t6_rst_grf_valid", 64'(wbif.o_grfValid), 64'(0));
    chk("t6_rst_st_valid",  64'(wbif.o_stValid),  64'(0));
    chk("t6_rst_ptr",       64'(commit_ptr),      64'(0));
    chk("t6_rst_cycle_end", 64'(cycle_end),       64'(0));
    chk("t6_rst_err",       64'(err),             64'(0));
    rst = 1'b0;
    wbif.i_grfReady = 1'b1;
    tick();
    exp_grf(11, 'hB1); exp_grf(12, 'hB2);
    cend_pending++;
    start(1);
    set_cmp(0, 0, 11, 'hB1, 1'b0);
    set_cmp(1, 1, 12, 'hB2, 1'b0);
    cmp_tick();
    wait_cend(20);
    chk("t6_err_clean", 64'(err), 64'(0));

    repeat (3) tick();
    chk("end_grf_queue_empty",  64'(grf_q.size()), 64'(0));
    chk("end_st_queue_empty",   64'(st_q.size()),  64'(0));
    chk("end_cend_all_seen",    64'(cend_pending), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
